// File: rtl/settings_bus_fifo_pkg.sv
// Shared settings-bus definitions: bus data width and the half-select encoding
// used to place 16-bit Wishbone writes into the 32-bit assembly word.
package settings_bus_fifo_pkg;

  localparam int unsigned SB_DATA_W = 32;
  localparam int unsigned SB_HALF_W = SB_DATA_W / 2;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  // adr[1] picks the half; BIG_ENDIAN swaps which half is written first.
  function automatic logic half_sel(input logic adr1, input logic big_endian);
    return (adr1 ^ big_endian) ? HALF_HI : HALF_LO;
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// Small synchronous FIFO with registered occupancy; output reads as zero when empty.
module sb_fifo #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned AW    = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset: it is only observable through a non-zero level.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  assign o_dout = o_empty ? '0 : r_mem[r_rptr];

endmodule

// File: rtl/settings_bus_fifo.sv
// Wishbone slave to settings-bus bridge: assembles 16/32-bit writes into 32-bit
// settings words, queues committed writes, and stalls ack while the queue is full.
module settings_bus_fifo
  import settings_bus_fifo_pkg::*;
#(
  parameter int unsigned AWIDTH     = 16,
  parameter int unsigned DWIDTH     = 16,
  parameter int unsigned RWIDTH     = 8,
  parameter bit          BIG_ENDIAN = 1'b0,
  parameter int unsigned FIFO_AW    = 2
) (
  input  logic               wb_clk,
  input  logic               wb_rst,
  input  logic [AWIDTH-1:0]  wb_adr_i,
  input  logic [DWIDTH-1:0]  wb_dat_i,
  output logic [DWIDTH-1:0]  wb_dat_o,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  output logic               wb_ack_o,
  output logic               set_stb,
  output logic [RWIDTH-1:0]  set_addr,
  output logic [31:0]        set_data,
  input  logic               set_rdy,
  output logic [FIFO_AW:0]   fifo_level
);

  logic [SB_DATA_W-1:0]        r_asm;
  logic                        r_pending;
  logic                        r_ack;
  logic [DWIDTH-1:0]           r_dat_o;

  logic [SB_DATA_W-1:0]        w_din;
  logic [SB_DATA_W-1:0]        w_word;
  logic [DWIDTH-1:0]           w_rdata;
  logic                        w_half;
  logic                        w_commit;
  logic                        w_full;
  logic                        w_empty;
  logic                        w_ack_next;
  logic                        w_push;
  logic                        w_pop;
  logic [RWIDTH+SB_DATA_W-1:0] w_head;
  logic                        w_unused;

  assign w_din  = SB_DATA_W'(wb_dat_i);
  assign w_half = half_sel(wb_adr_i[1], BIG_ENDIAN);

  // The word pushed on a commit includes the half arriving in the same cycle.
  always_comb begin
    w_commit = wb_we_i;
    w_word   = w_din;
    w_rdata  = DWIDTH'(r_asm);
    if (DWIDTH != SB_DATA_W) begin
      w_commit = wb_we_i & wb_adr_i[1];
      w_word   = (w_half == HALF_LO)
               ? {r_asm[SB_DATA_W-1:SB_HALF_W], w_din[SB_HALF_W-1:0]}
               : {w_din[SB_HALF_W-1:0], r_asm[SB_HALF_W-1:0]};
      w_rdata  = DWIDTH'((w_half == HALF_LO) ? r_asm[SB_HALF_W-1:0]
                                             : r_asm[SB_DATA_W-1:SB_HALF_W]);
    end
  end

  // Full is the registered level: a same-cycle pop does not admit a push.
  assign w_ack_next = wb_stb_i & ~r_ack & ~(w_commit & w_full);
  assign w_push     = w_ack_next & w_commit;
  assign w_pop      = ~w_empty & set_rdy;

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_ack     <= 1'b0;
      r_asm     <= '0;
      r_pending <= 1'b0;
      r_dat_o   <= '0;
    end else begin
      r_ack <= w_ack_next;
      if (w_ack_next) begin
        if (wb_we_i) begin
          r_asm     <= w_word;
          r_pending <= ~w_commit;
        end else begin
          r_dat_o   <= w_rdata;
        end
      end
    end
  end

  sb_fifo #(
    .WIDTH (RWIDTH + SB_DATA_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .i_clk   (wb_clk),
    .i_rst   (wb_rst),
    .i_push  (w_push),
    .i_din   ({wb_adr_i[RWIDTH+1:2], w_word}),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat_o;
  assign set_stb  = ~w_empty;
  assign set_addr = w_head[RWIDTH+SB_DATA_W-1:SB_DATA_W];
  assign set_data = w_head[SB_DATA_W-1:0];

  // Address bits outside the register field and the pending flag have no consumer here.
  assign w_unused = &{1'b0, wb_adr_i, r_pending};

endmodule

// File: tb/tb_settings_bus_fifo.sv
// Bench for settings_bus_fifo: LE16, BE16 and 32-bit instances checked every cycle
// against a queue-based reference model, plus directed literal scenarios.
module tb_settings_bus_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] adr   [3];
  logic [31:0] din   [3];
  logic        stb   [3];
  logic        we    [3];
  logic        rdy   [3];
  logic        ack   [3];
  logic        sstb  [3];
  logic [7:0]  saddr [3];
  logic [31:0] sdata [3];
  logic [2:0]  level [3];
  logic [31:0] dato  [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic void chk(input int k, input string name,
                              input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL inst%0d %s: got 0x%0h, expected 0x%0h (t=%0t)", k, name, act, exp, $time);
    end
  endfunction

  // inst[0]: 16-bit little-endian, inst[1]: 16-bit big-endian, inst[2]: 32-bit
  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int unsigned DW = (g == 2) ? 32 : 16;
    localparam bit          BE = (g == 1);

    logic [DW-1:0] w_dato;

    settings_bus_fifo #(
      .AWIDTH     (16),
      .DWIDTH     (DW),
      .RWIDTH     (8),
      .BIG_ENDIAN (BE),
      .FIFO_AW    (2)
    ) dut (
      .wb_clk     (clk),
      .wb_rst     (rst),
      .wb_adr_i   (adr[g]),
      .wb_dat_i   (din[g][DW-1:0]),
      .wb_dat_o   (w_dato),
      .wb_stb_i   (stb[g]),
      .wb_we_i    (we[g]),
      .wb_ack_o   (ack[g]),
      .set_stb    (sstb[g]),
      .set_addr   (saddr[g]),
      .set_data   (sdata[g]),
      .set_rdy    (rdy[g]),
      .fifo_level (level[g])
    );

    assign dato[g] = 32'(w_dato);

    logic [39:0] mq [$];
    logic [31:0] masm;
    logic [31:0] mdato;
    logic        mack;

    always @(posedge clk or posedge rst) begin : model
      logic        full, commit, lo, take;
      logic [31:0] word;
      if (rst) begin
        mq.delete();
        masm  = '0;
        mdato = '0;
        mack  = 1'b0;
      end else begin
        full   = (mq.size() == 4);
        commit = we[g] && (DW == 32 || adr[g][1]);
        take   = stb[g] && !mack && !(commit && full);
        lo     = (adr[g][1] == BE);
        if (mq.size() != 0 && rdy[g]) void'(mq.pop_front());
        if (take && we[g]) begin
          if (DW == 32) word = din[g];
          else if (lo)  word = {masm[31:16], din[g][15:0]};
          else          word = {din[g][15:0], masm[15:0]};
          masm = word;
          if (commit) mq.push_back({adr[g][9:2], word});
        end else if (take) begin
          if (DW == 32) mdato = masm;
          else if (lo)  mdato = {16'h0, masm[15:0]};
          else          mdato = {16'h0, masm[31:16]};
        end
        mack = take;
      end
    end

    always @(negedge clk) begin
      if (!rst) begin
        chk(g, "ack", 64'(ack[g]), 64'(mack));
        chk(g, "set_stb", 64'(sstb[g]), 64'(mq.size() != 0));
        chk(g, "fifo_level", 64'(level[g]), 64'(mq.size()));
        chk(g, "wb_dat_o", 64'(dato[g]), 64'(mdato));
        if (mq.size() != 0) begin
          chk(g, "set_addr", 64'(saddr[g]), 64'(mq[0][39:32]));
          chk(g, "set_data", 64'(sdata[g]), 64'(mq[0][31:0]));
        end
      end
    end
  end

  // Drive one transaction; return the number of negedges until ack was seen.
  task automatic xfer(input int k, input logic w, input logic [15:0] a,
                      input logic [31:0] d, output int waited);
    @(negedge clk);
    adr[k] = a; din[k] = d; we[k] = w; stb[k] = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!ack[k] && waited < 40);
    chk(k, "ack_seen", 64'(ack[k]), 64'd1);
    stb[k] = 1'b0; we[k] = 1'b0;
  endtask

  task automatic rand_traffic(input int k, input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      xfer(k, 1'($urandom_range(0, 1)), 16'($urandom), $urandom, w);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int  n;
    logic done;
    for (int k = 0; k < 3; k++) begin
      adr[k] = '0; din[k] = '0; stb[k] = 1'b0; we[k] = 1'b0; rdy[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk(k, "rst_ack", 64'(ack[k]), 64'd0);
      chk(k, "rst_set_stb", 64'(sstb[k]), 64'd0);
      chk(k, "rst_level", 64'(level[k]), 64'd0);
      chk(k, "rst_set_data", 64'(sdata[k]), 64'd0);
    end
    rst = 1'b0;

    // LE16 assembly and commit
    xfer(0, 1'b1, 16'h0010, 32'h5678, n);
    chk(0, "t1_lo_wait", 64'(n), 64'd1);
    chk(0, "t1_lo_no_stb", 64'(sstb[0]), 64'd0);
    xfer(0, 1'b1, 16'h0012, 32'h1234, n);
    chk(0, "t1_stb", 64'(sstb[0]), 64'd1);
    chk(0, "t1_addr", 64'(saddr[0]), 64'h04);
    chk(0, "t1_data", 64'(sdata[0]), 64'h12345678);
    @(negedge clk);
    chk(0, "t1_single_stb", 64'(sstb[0]), 64'd0);

    // Stale low half reused by a lone commit
    xfer(0, 1'b1, 16'h0006, 32'hCCCC, n);
    chk(0, "t4_addr", 64'(saddr[0]), 64'h01);
    chk(0, "t4_data", 64'(sdata[0]), 64'hCCCC5678);
    xfer(0, 1'b0, 16'h0010, 32'h0, n);
    chk(0, "t4_rd_lo", 64'(dato[0]), 64'h5678);
    xfer(0, 1'b0, 16'h0012, 32'h0, n);
    chk(0, "t4_rd_hi", 64'(dato[0]), 64'hCCCC);

    // Big-endian half order
    xfer(1, 1'b1, 16'h0020, 32'hAAAA, n);
    xfer(1, 1'b1, 16'h0022, 32'hBBBB, n);
    chk(1, "t2_addr", 64'(saddr[1]), 64'h08);
    chk(1, "t2_data", 64'(sdata[1]), 64'hAAAABBBB);
    xfer(1, 1'b0, 16'h0020, 32'h0, n);
    chk(1, "t2_rd_hi", 64'(dato[1]), 64'hAAAA);

    // 32-bit data path
    xfer(2, 1'b1, 16'h03FC, 32'hDEADBEEF, n);
    chk(2, "t6_addr", 64'(saddr[2]), 64'hFF);
    chk(2, "t6_data", 64'(sdata[2]), 64'hDEADBEEF);
    xfer(2, 1'b0, 16'h03FC, 32'h0, n);
    chk(2, "t6_rd", 64'(dato[2]), 64'hDEADBEEF);

    // Backpressure: four commits fill the FIFO, the fifth stalls
    repeat (2) @(negedge clk);
    rdy[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      xfer(0, 1'b1, 16'(16'h0012 + 4 * i), 32'(16'h1000 + i), n);
      chk(0, "t3_prompt_ack", 64'(n), 64'd1);
    end
    chk(0, "t3_level_full", 64'(level[0]), 64'd4);
    chk(0, "t3_head_addr", 64'(saddr[0]), 64'h04);
    chk(0, "t3_head_data", 64'(sdata[0]), 64'h10005678);
    @(negedge clk);
    adr[0] = 16'h0022; din[0] = 32'h1004; we[0] = 1'b1; stb[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk(0, "t3_stalled", 64'(ack[0]), 64'd0);
    end
    rdy[0] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack[0] && n < 20);
    stb[0] = 1'b0; we[0] = 1'b0;
    chk(0, "t3_ack_delay", 64'(n), 64'd2);
    repeat (6) @(negedge clk);
    chk(0, "t3_drained", 64'(level[0]), 64'd0);

    // Asynchronous reset with queued entries and a pending half
    rdy[0] = 1'b0;
    for (int i = 0; i < 3; i++) xfer(0, 1'b1, 16'(16'h0032 + 4 * i), 32'h7777, n);
    xfer(0, 1'b1, 16'h0040, 32'h9999, n);
    chk(0, "t5_level3", 64'(level[0]), 64'd3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk(0, "t5_rst_stb", 64'(sstb[0]), 64'd0);
    chk(0, "t5_rst_level", 64'(level[0]), 64'd0);
    chk(0, "t5_rst_ack", 64'(ack[0]), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rdy[0] = 1'b1;
    xfer(0, 1'b1, 16'h0012, 32'hABCD, n);
    chk(0, "t5_addr", 64'(saddr[0]), 64'h04);
    chk(0, "t5_data", 64'(sdata[0]), 64'hABCD0000);

    // Randomized traffic with random backpressure on each instance
    for (int k = 0; k < 3; k++) begin
      done = 1'b0;
      fork
        begin
          rand_traffic(k, 80);
          done = 1'b1;
        end
        begin
          while (!done) begin
            @(negedge clk);
            rdy[k] = ($urandom_range(0, 2) != 0);
          end
        end
      join
      rdy[k] = 1'b1;
      repeat (8) @(negedge clk);
      chk(k, "rand_drained", 64'(level[k]), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
